wb_regfile_stage: RTL and testbench

Writeback-end consumer of the MEM/WB pipeline interface. Selects the writeback result and commits it to the 15-entry ARM general register file (R0-R14). Supplies three decode-stage read ports with write-through bypass, and converts PCSrcW writebacks into a one-cycle registered PC redirect for fetch. Also keeps a saturating retire counter for debug and camera-test instrumentation.

---
 rtl/arm_pkg.sv | 12 +
 rtl/regfile_3r1w.sv | 50 +++++
 rtl/wb_regfile_stage.sv | 112 +++++++++++
 tb/tb_wb_regfile_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants and basic datapath types.
package arm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 15;
  localparam logic [3:0]  PC_IDX = 4'd15;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_addr_t;

endpackage

// File: rtl/regfile_3r1w.sv
// 15-entry general register storage: one write port, three raw read ports.
// Addresses at or beyond NREGS read as zero and are never written.
module regfile_3r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state of the array: copy, then overlay the single write.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr < LIMIT)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Raw combinational read ports.
  always_comb begin
    rd1 = (ra1 < LIMIT) ? regs_q[ra1] : '0;
    rd2 = (ra2 < LIMIT) ? regs_q[ra2] : '0;
    rd3 = (ra3 < LIMIT) ? regs_q[ra3] : '0;
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: result select, register commit, decode read ports with
// R15 substitution and write-through bypass, PC redirect, retire counter.
module wb_regfile_stage
  import arm_pkg::PC_IDX;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 15,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic              MemToRegW,
  input  logic              RegWriteW,
  input  logic              PCSrcW,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] RA3D,
  input  logic [DATA_W-1:0] PCPlus8D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] RD3D,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCRedirect,
  output logic [DATA_W-1:0] PCRedirectTarget,
  output logic [CNT_W-1:0]  RetireCount
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic              reg_we;
  logic [DATA_W-1:0] raw1, raw2, raw3;
  logic              redir_q, redir_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Per-port read resolution: R15 first, then same-cycle bypass, then storage.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] raw,
    input logic [DATA_W-1:0] pc8,
    input logic              wr,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] res
  );
    if (ra == PC_A)           return pc8;
    else if (wr && (wa == ra)) return res;
    else                       return raw;
  endfunction

  // Writeback result select and register write qualification.
  always_comb begin
    ResultW = MemToRegW ? ReadDataW : ALUOutW;
    reg_we  = RegWriteW && (WA3W != PC_A);
  end

  regfile_3r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .waddr (WA3W),
    .wdata (ResultW),
    .ra1   (RA1D),
    .ra2   (RA2D),
    .ra3   (RA3D),
    .rd1   (raw1),
    .rd2   (raw2),
    .rd3   (raw3)
  );

  // Decode read ports.
  always_comb begin
    RD1D = resolve(RA1D, raw1, PCPlus8D, RegWriteW, WA3W, ResultW);
    RD2D = resolve(RA2D, raw2, PCPlus8D, RegWriteW, WA3W, ResultW);
    RD3D = resolve(RA3D, raw3, PCPlus8D, RegWriteW, WA3W, ResultW);
  end

  // Redirect strobe/target and saturating retire counter next-state.
  always_comb begin
    redir_d = PCSrcW;
    tgt_d   = PCSrcW ? ResultW : tgt_q;
    cnt_d   = cnt_q;
    if ((RegWriteW || PCSrcW) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Redirect and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_q <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCRedirect       = redir_q;
  assign PCRedirectTarget = tgt_q;
  assign RetireCount      = cnt_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: vector table plus reset and
// counter-saturation sequences. A second instance uses a 4-bit counter.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ReadDataW, ALUOutW, PCPlus8D;
  logic [3:0]  WA3W, RA1D, RA2D, RA3D;
  logic        MemToRegW, RegWriteW, PCSrcW;

  logic [31:0] RD1D, RD2D, RD3D, ResultW, PCRedirectTarget, RetireCount;
  logic        PCRedirect;
  logic [31:0] RD1D_s, RD2D_s, RD3D_s, ResultW_s, PCRedirectTarget_s;
  logic        PCRedirect_s;
  logic [3:0]  RetireCount_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .WA3W(WA3W), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D), .PCPlus8D(PCPlus8D),
    .RD1D(RD1D), .RD2D(RD2D), .RD3D(RD3D), .ResultW(ResultW),
    .PCRedirect(PCRedirect), .PCRedirectTarget(PCRedirectTarget),
    .RetireCount(RetireCount)
  );

  wb_regfile_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .WA3W(WA3W), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D), .PCPlus8D(PCPlus8D),
    .RD1D(RD1D_s), .RD2D(RD2D_s), .RD3D(RD3D_s), .ResultW(ResultW_s),
    .PCRedirect(PCRedirect_s), .PCRedirectTarget(PCRedirectTarget_s),
    .RetireCount(RetireCount_s)
  );

  typedef struct {
    logic        rw;
    logic [3:0]  wa;
    logic        m2r;
    logic        pcs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [3:0]  ra1, ra2, ra3;
    logic [31:0] pc8;
    logic [31:0] e_res, e_rd1, e_rd2, e_rd3;
    logic        e_redir;
    logic [31:0] e_tgt;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [3:0] wa, input logic m2r,
                       input logic pcs, input logic [31:0] alu, input logic [31:0] rdata);
    RegWriteW = rw; WA3W = wa; MemToRegW = m2r; PCSrcW = pcs;
    ALUOutW = alu; ReadDataW = rdata;
  endtask

  initial begin
    // rw wa m2r pcs alu rdata ra1 ra2 ra3 pc8 | res rd1 rd2 rd3 | redir tgt cnt
    vecs[0]  = '{1'b1, 4'd5,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 4'd5,  4'd15, 4'd3,  32'h108,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h108, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[1]  = '{1'b0, 4'd5,  1'b0, 1'b0, 32'h0, 32'h0, 4'd5, 4'd2, 4'd0, 32'h108,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[2]  = '{1'b1, 4'd2,  1'b1, 1'b0, 32'hFFFFFFFF, 32'h12345678, 4'd2, 4'd5, 4'd15, 32'h10C,
                 32'h12345678, 32'h12345678, 32'hDEADBEEF, 32'h10C, 1'b0, 32'h0, 32'd2};
    vecs[3]  = '{1'b1, 4'd15, 1'b0, 1'b1, 32'h200, 32'h0, 4'd15, 4'd2, 4'd5, 32'h110,
                 32'h200, 32'h110, 32'h12345678, 32'hDEADBEEF, 1'b1, 32'h200, 32'd3};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 4'd5, 4'd14, 32'h110,
                 32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0, 1'b0, 32'h200, 32'd3};
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b1, 32'h300, 32'h0, 4'd2, 4'd5, 4'd14, 32'h110,
                 32'h300, 32'h12345678, 32'hDEADBEEF, 32'h0, 1'b1, 32'h300, 32'd4};
    vecs[6]  = '{1'b1, 4'd4,  1'b0, 1'b1, 32'h304, 32'h0, 4'd4, 4'd2, 4'd5, 32'h110,
                 32'h304, 32'h304, 32'h12345678, 32'hDEADBEEF, 1'b1, 32'h304, 32'd5};
    vecs[7]  = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h55, 32'h0, 4'd4, 4'd15, 4'd0, 32'h118,
                 32'h55, 32'h304, 32'h118, 32'h0, 1'b0, 32'h304, 32'd6};
    vecs[8]  = '{1'b1, 4'd14, 1'b0, 1'b0, 32'hAA, 32'h0, 4'd14, 4'd4, 4'd15, 32'h11C,
                 32'hAA, 32'hAA, 32'h304, 32'h11C, 1'b0, 32'h304, 32'd7};
    vecs[9]  = '{1'b0, 4'd14, 1'b1, 1'b0, 32'h0, 32'h77, 4'd14, 4'd0, 4'd4, 32'h11C,
                 32'h77, 32'hAA, 32'h0, 32'h304, 1'b0, 32'h304, 32'd7};
    vecs[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 32'h11, 32'h0, 4'd14, 4'd0, 4'd0, 32'h11C,
                 32'h11, 32'hAA, 32'h11, 32'h11, 1'b0, 32'h304, 32'd8};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    RA1D = 4'd3; RA2D = 4'd15; RA3D = 4'd0; PCPlus8D = 32'h108;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", RD1D, 32'h0);
    chk("reset_rd2_r15", RD2D, 32'h108);
    chk("reset_redir", {31'b0, PCRedirect}, 32'h0);
    chk("reset_tgt", PCRedirectTarget, 32'h0);
    chk("reset_cnt", RetireCount, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: combinational checks before the edge,
    // registered checks just after it.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].wa, vecs[i].m2r, vecs[i].pcs, vecs[i].alu, vecs[i].rdata);
      RA1D = vecs[i].ra1; RA2D = vecs[i].ra2; RA3D = vecs[i].ra3; PCPlus8D = vecs[i].pc8;
      #1;
      chk($sformatf("v%0d_result", i), ResultW, vecs[i].e_res);
      chk($sformatf("v%0d_rd1", i), RD1D, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), RD2D, vecs[i].e_rd2);
      chk($sformatf("v%0d_rd3", i), RD3D, vecs[i].e_rd3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_redir", i), {31'b0, PCRedirect}, {31'b0, vecs[i].e_redir});
      chk($sformatf("v%0d_tgt", i), PCRedirectTarget, vecs[i].e_tgt);
      chk($sformatf("v%0d_cnt", i), RetireCount, vecs[i].e_cnt);
    end

    // Reset pulse while a write and redirect are pending
    @(negedge clk);
    drive(1'b1, 4'd7, 1'b0, 1'b1, 32'hAA, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_async_cnt", RetireCount, 32'h0);
    chk("rst_async_redir", {31'b0, PCRedirect}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    RA1D = 4'd7; RA2D = 4'd14; RA3D = 4'd4;
    #1;
    chk("rst_r7", RD1D, 32'h0);
    chk("rst_r14", RD2D, 32'h0);
    chk("rst_r4", RD3D, 32'h0);
    chk("rst_cnt", RetireCount, 32'h0);
    chk("rst_redir", {31'b0, PCRedirect}, 32'h0);
    chk("rst_tgt", PCRedirectTarget, 32'h0);

    // First write after reset is accepted
    @(negedge clk);
    drive(1'b1, 4'd7, 1'b0, 1'b0, 32'hBB, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("post_rst_r7", RD1D, 32'hBB);
    chk("post_rst_cnt", RetireCount, 32'd1);
    chk("post_rst_cnt_sat", {28'b0, RetireCount_s}, 32'd1);

    // 20 retiring writebacks to R15: narrow counter saturates at 0xF
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1'b1, 4'd15, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt4_%0d", k), {28'b0, RetireCount_s}, (1 + k > 15) ? 32'd15 : 32'(1 + k));
      chk($sformatf("sat_cnt32_%0d", k), RetireCount, 32'(1 + k));
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("r7_after_r15_writes", RD1D, 32'hBB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
